branch_predictor: RTL
=====================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter PC_WIDTH, default 32: width of all PC and target fields.
REQ-002 Parameter ENTRIES, default 16, power of two, ≥2: number of BTB entries; IDX_W = log2(ENTRIES).
REQ-003 Parameter CNT_WIDTH, default 32: width of the performance counters.
REQ-004 One clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock; all state updates on the rising edge.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 lookup_valid  input  1  fetch_pc is a real fetch this cycle.
REQ-008 fetch_pc  input  PC_WIDTH  PC being fetched.
REQ-009 predict_take_branch  output  1  predicted taken for fetch_pc; combinational.
REQ-010 predict_target_pc  output  PC_WIDTH  predicted target for fetch_pc; combinational.
REQ-011 predict_hit  output  1  fetch_pc matched a valid BTB entry; combinational.
REQ-012 upd_valid  input  1  resolved-branch update from execute this cycle.
REQ-013 upd_pc  input  PC_WIDTH  PC of the resolved branch.
REQ-014 upd_taken  input  1  resolved branch direction.
REQ-015 upd_target  input  PC_WIDTH  resolved taken target.
REQ-016 upd_mispredict  input  1  execute detected a misprediction for this branch.
REQ-017 lookup_cnt  output  CNT_WIDTH  count of cycles with lookup_valid=1.
REQ-018 mispredict_cnt  output  CNT_WIDTH  count of cycles with upd_valid=1 and upd_mispredict=1.

Function
REQ-019 Index = pc[IDX_W+1:2]; tag = pc[PC_WIDTH-1:IDX_W+2]; pc[1:0] is ignored.
REQ-020 Each entry holds valid (1b), tag, target (PC_WIDTH), and a 2-bit saturating counter: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
REQ-021 predict_hit = lookup_valid & entry.valid & (entry.tag == tag(fetch_pc)).
REQ-022 predict_take_branch = predict_hit & counter[1].
REQ-023 predict_target_pc = entry.target when predict_hit; 0 otherwise.
REQ-024 Lookup uses registered table state only; there is no same-cycle bypass from the update port.
REQ-025 Update with upd_valid=1 and a tag hit at the indexed entry: counter increments (saturating at 11) if upd_taken, else decrements (saturating at 00); target is written with upd_target when upd_taken=1.
REQ-026 Update with upd_valid=1, a tag miss or invalid entry, and upd_taken=1: allocate the entry with valid=1, the new tag, target=upd_target, counter=10.
REQ-027 Update with upd_valid=1, a miss, and upd_taken=0: no table change.
REQ-028 An update becomes visible to lookups on the cycle after the update edge (one-cycle update latency).
REQ-029 Simultaneous lookup and update to the same index: lookup returns pre-update contents.
REQ-030 lookup_cnt and mispredict_cnt increment by 1 per qualifying cycle and saturate at all-ones (no wrap).
REQ-031 upd_mispredict is ignored when upd_valid=0.

Reset
REQ-032 While rst=1, asynchronously: all valid bits 0, all counters 01, all tags and targets 0, both performance counters 0.
REQ-033 Outputs during and immediately after reset: predict_hit=0, predict_take_branch=0, predict_target_pc=0.
REQ-034 Reset asserted in the same cycle as upd_valid=1 discards the update; no entry is valid after release.

Verification
REQ-035 After reset, lookup_valid=1, fetch_pc=0x100 -> hit=0, take=0, target=0; lookup_cnt=1 on the next cycle.
REQ-036 Update pc=0x100, taken=1, target=0x200; next cycle lookup 0x100 -> hit=1, take=1, target=0x200 (counter 10).
REQ-037 Two not-taken updates to 0x100 after REQ-036 -> counter 00, lookup hit=1, take=0; a third not-taken update leaves the counter at 00.
REQ-038 Aliasing: with ENTRIES=16, 0x100 allocated, then taken update of 0x140 (same index, different tag) -> 0x100 misses; 0x140 hits with its own target.
REQ-039 Same-cycle lookup and first taken update of 0x300 -> that cycle hit=0; next cycle hit=1, take=1.
REQ-040 Force mispredict_cnt to all-ones -> a further update with upd_mispredict=1 holds all-ones; assert rst mid-run -> all entries invalid and both counters 0 without waiting for a clock edge.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating direction counters.
// Lookup reads registered state only; updates land on the next edge.
module branch_predictor #(
   parameter int PC_WIDTH  = 32,
   parameter int ENTRIES   = 16,
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 lookup_valid,
   input  logic [PC_WIDTH-1:0]  fetch_pc,
   output logic                 predict_take_branch,
   output logic [PC_WIDTH-1:0]  predict_target_pc,
   output logic                 predict_hit,
   input  logic                 upd_valid,
   input  logic [PC_WIDTH-1:0]  upd_pc,
   input  logic                 upd_taken,
   input  logic [PC_WIDTH-1:0]  upd_target,
   input  logic                 upd_mispredict,
   output logic [CNT_WIDTH-1:0] lookup_cnt,
   output logic [CNT_WIDTH-1:0] mispredict_cnt
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = PC_WIDTH - IDX_W - 2;
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic                valid_q [ENTRIES];
   logic                valid_d [ENTRIES];
   logic [TAG_W-1:0]    tag_q   [ENTRIES];
   logic [TAG_W-1:0]    tag_d   [ENTRIES];
   logic [PC_WIDTH-1:0] tgt_q   [ENTRIES];
   logic [PC_WIDTH-1:0] tgt_d   [ENTRIES];
   logic [1:0]          ctr_q   [ENTRIES];
   logic [1:0]          ctr_d   [ENTRIES];

   logic [CNT_WIDTH-1:0] lookup_cnt_q, lookup_cnt_d;
   logic [CNT_WIDTH-1:0] mispredict_cnt_q, mispredict_cnt_d;

   logic [IDX_W-1:0] f_idx, u_idx;
   logic [TAG_W-1:0] f_tag, u_tag;
   logic             u_hit;
   logic             unused_pc_bits;

   assign f_idx = fetch_pc[IDX_W+1:2];
   assign f_tag = fetch_pc[PC_WIDTH-1:IDX_W+2];
   assign u_idx = upd_pc[IDX_W+1:2];
   assign u_tag = upd_pc[PC_WIDTH-1:IDX_W+2];
   assign u_hit = valid_q[u_idx] & (tag_q[u_idx] == u_tag);

   // byte offset within the instruction word never selects an entry
   assign unused_pc_bits = ^{fetch_pc[1:0], upd_pc[1:0]};

   // prediction from the registered table, gated by a real fetch
   always_comb begin
      predict_hit         = lookup_valid & valid_q[f_idx] & (tag_q[f_idx] == f_tag);
      predict_take_branch = predict_hit & ctr_q[f_idx][1];
      predict_target_pc   = predict_hit ? tgt_q[f_idx] : '0;
   end

   // train on a hit, allocate weak-taken on a taken miss
   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tgt_d   = tgt_q;
      ctr_d   = ctr_q;
      if (upd_valid) begin
         if (u_hit) begin
            if (upd_taken) begin
               tgt_d[u_idx] = upd_target;
               if (ctr_q[u_idx] != 2'b11) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
            end else begin
               if (ctr_q[u_idx] != 2'b00) ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            valid_d[u_idx] = 1'b1;
            tag_d[u_idx]   = u_tag;
            tgt_d[u_idx]   = upd_target;
            ctr_d[u_idx]   = 2'b10;
         end
      end
   end

   // saturating performance counters
   always_comb begin
      lookup_cnt_d     = lookup_cnt_q;
      mispredict_cnt_d = mispredict_cnt_q;
      if (lookup_valid && (lookup_cnt_q != '1))
         lookup_cnt_d = lookup_cnt_q + CNT_ONE;
      if (upd_valid && upd_mispredict && (mispredict_cnt_q != '1))
         mispredict_cnt_d = mispredict_cnt_q + CNT_ONE;
   end

   // table and counter state, cleared asynchronously
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= 2'b01;
         end
         lookup_cnt_q     <= '0;
         mispredict_cnt_q <= '0;
      end else begin
         valid_q          <= valid_d;
         tag_q            <= tag_d;
         tgt_q            <= tgt_d;
         ctr_q            <= ctr_d;
         lookup_cnt_q     <= lookup_cnt_d;
         mispredict_cnt_q <= mispredict_cnt_d;
      end
   end

   assign lookup_cnt     = lookup_cnt_q;
   assign mispredict_cnt = mispredict_cnt_q;

endmodule
